dac714_serial_tx: RTL and testbench

//  Receiving end of the ramp generator's DAC output interface (Yis + DACStrobe).

---
 rtl/dac714_serial_tx.sv | 162 ++++++++++++++++
 tb/tb_dac714_serial_tx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dac714_serial_tx.sv
// DAC714 serial transmitter: captures a DAC word on each strobe and shifts it MSB-first
// over SCLK/SDI, then pulses nLATCH. One pending word is buffered; overwrites are counted.
module dac714_serial_tx #(
    parameter int unsigned DAC_WIDTH     = 16,
    parameter int unsigned SCLK_DIV      = 1,
    parameter int unsigned LATCH_WIDTH   = 2,
    parameter int unsigned OFFSET_BINARY = 0
) (
    input  logic                 clk_slow,
    input  logic                 nReset,
    input  logic                 enable,
    input  logic                 dac_strobe,
    input  logic [DAC_WIDTH-1:0] dac_data,
    output logic                 sclk,
    output logic                 sdi,
    output logic                 nlatch,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           overrun_cnt,
    output logic [DAC_WIDTH-1:0] last_sent
);

    localparam int unsigned BIT_W = (DAC_WIDTH > 1) ? $clog2(DAC_WIDTH) : 1;
    localparam int unsigned DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int unsigned LAT_W = (LATCH_WIDTH > 1) ? $clog2(LATCH_WIDTH) : 1;

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DAC_WIDTH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATCH_WIDTH - 1);

    localparam logic [DAC_WIDTH-1:0] MSB_MASK =
        (OFFSET_BINARY != 0) ? {1'b1, {(DAC_WIDTH-1){1'b0}}} : '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               state;
    logic [2:0]           strobe_sync;
    logic                 strobe_rise;
    logic                 capture;
    logic                 load;
    logic                 pend_valid;
    logic [DAC_WIDTH-1:0] pend_data;
    logic [DAC_WIDTH-1:0] shreg;
    logic [DAC_WIDTH-1:0] frame_word;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DIV_W-1:0]     div_cnt;
    logic [LAT_W-1:0]     lat_cnt;

    // Two synchronizer flops plus one history flop for rising-edge detection
    always_ff @(posedge clk_slow) begin
        if (!nReset) begin
            strobe_sync <= '0;
        end else begin
            strobe_sync <= {strobe_sync[1:0], dac_strobe};
        end
    end

    assign strobe_rise = strobe_sync[1] & ~strobe_sync[2];
    assign capture     = strobe_rise & enable;
    assign load        = (state == ST_IDLE) & pend_valid;

    // Pending slot: a capture coinciding with a load keeps the new word and is not an overrun
    always_ff @(posedge clk_slow) begin
        if (!nReset) begin
            pend_valid  <= 1'b0;
            pend_data   <= '0;
            overrun_cnt <= '0;
        end else if (capture) begin
            pend_data  <= dac_data ^ MSB_MASK;
            pend_valid <= 1'b1;
            if (pend_valid && !load && (overrun_cnt != 8'hFF)) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end
        end else if (load) begin
            pend_valid <= 1'b0;
        end
    end

    // Frame sequencer; every output is a register updated alongside the state
    always_ff @(posedge clk_slow) begin
        if (!nReset) begin
            state      <= ST_IDLE;
            sclk       <= 1'b0;
            sdi        <= 1'b0;
            nlatch     <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            last_sent  <= '0;
            shreg      <= '0;
            frame_word <= '0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            lat_cnt    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pend_valid) begin
                        state      <= ST_SHIFT;
                        shreg      <= pend_data;
                        frame_word <= pend_data;
                        sdi        <= pend_data[DAC_WIDTH-1];
                        sclk       <= 1'b0;
                        div_cnt    <= '0;
                        bit_cnt    <= '0;
                        busy       <= 1'b1;
                    end
                end

                ST_SHIFT: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end else begin
                        div_cnt <= '0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else begin
                            sclk <= 1'b0;
                            if (bit_cnt == BIT_LAST) begin
                                state   <= ST_LATCH;
                                sdi     <= 1'b0;
                                nlatch  <= 1'b0;
                                lat_cnt <= '0;
                            end else begin
                                // Next bit goes out on the falling edge, ahead of its rise
                                bit_cnt <= bit_cnt + BIT_W'(1);
                                shreg   <= shreg << 1;
                                sdi     <= shreg[DAC_WIDTH-2];
                            end
                        end
                    end
                end

                ST_LATCH: begin
                    if (lat_cnt == LAT_LAST) begin
                        state     <= ST_DONE;
                        nlatch    <= 1'b1;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        last_sent <= frame_word;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac714_serial_tx.sv
// Bench for dac714_serial_tx: two instances (plain and offset-binary) share stimulus;
// a slot/timing reference model feeds per-instance scoreboards checked on each done pulse.
module tb_dac714_serial_tx;

    localparam int FRAME_SPAN = 36;   // load edge to the next possible load edge
    localparam int SYNC_LAT   = 3;    // drive edge to pending-set edge

    logic        clk_slow = 1'b0;
    logic        nReset;
    logic        enable;
    logic        dac_strobe;
    logic [15:0] dac_data;

    logic [1:0]  sclk_v, sdi_v, nlatch_v, busy_v, done_v;
    logic [7:0]  ovr_v  [2];
    logic [15:0] last_v [2];

    always #50 clk_slow = ~clk_slow;

    dac714_serial_tx #(.OFFSET_BINARY(0)) u_dut0 (
        .clk_slow(clk_slow), .nReset(nReset), .enable(enable),
        .dac_strobe(dac_strobe), .dac_data(dac_data),
        .sclk(sclk_v[0]), .sdi(sdi_v[0]), .nlatch(nlatch_v[0]),
        .busy(busy_v[0]), .done(done_v[0]),
        .overrun_cnt(ovr_v[0]), .last_sent(last_v[0])
    );

    dac714_serial_tx #(.OFFSET_BINARY(1)) u_dut1 (
        .clk_slow(clk_slow), .nReset(nReset), .enable(enable),
        .dac_strobe(dac_strobe), .dac_data(dac_data),
        .sclk(sclk_v[1]), .sdi(sdi_v[1]), .nlatch(nlatch_v[1]),
        .busy(busy_v[1]), .done(done_v[1]),
        .overrun_cnt(ovr_v[1]), .last_sent(last_v[1])
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one pending slot, fixed frame span, saturating overrun count
    int          cyc = 0;
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    bit          slot_valid = 1'b0;
    logic [15:0] slot_word  = '0;
    int          slot_load  = 0;
    int          next_free  = 0;
    int          model_ovr  = 0;

    task automatic commit_slot();
        q0.push_back(slot_word);
        q1.push_back(slot_word ^ 16'h8000);
        next_free  = slot_load + FRAME_SPAN;
        slot_valid = 1'b0;
    endtask

    task automatic model_strobe(input logic [15:0] word);
        int p;
        p = cyc + SYNC_LAT;
        if (slot_valid && slot_load <= p) commit_slot();
        if (slot_valid) begin
            slot_word = word;
            if (model_ovr < 255) model_ovr++;
        end else begin
            slot_valid = 1'b1;
            slot_word  = word;
            slot_load  = (p + 1 > next_free) ? p + 1 : next_free;
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        slot_valid = 1'b0;
        next_free  = 0;
        model_ovr  = 0;
    endtask

    task automatic step();
        @(posedge clk_slow);
        cyc++;
        #1;
        if (slot_valid && cyc >= slot_load) commit_slot();
    endtask

    task automatic strobe(input logic [15:0] word, input int hi, input int lo);
        dac_data   = word;
        dac_strobe = 1'b1;
        if (enable) model_strobe(word);
        repeat (hi) step();
        dac_strobe = 1'b0;
        repeat (lo) step();
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || slot_valid) && n < 600) begin
            step();
            n++;
        end
        check({name, "_drain_in_time"}, 32'(n < 600), 32'd1);
        repeat (3) step();
    endtask

    task automatic check_reset(input string name);
        for (int g = 0; g < 2; g++) begin
            check({name, "_sclk"},   32'(sclk_v[g]),   32'd0);
            check({name, "_sdi"},    32'(sdi_v[g]),    32'd0);
            check({name, "_nlatch"}, 32'(nlatch_v[g]), 32'd1);
            check({name, "_busy"},   32'(busy_v[g]),   32'd0);
            check({name, "_done"},   32'(done_v[g]),   32'd0);
            check({name, "_ovr"},    32'(ovr_v[g]),    32'd0);
            check({name, "_last"},   32'(last_v[g]),   32'd0);
        end
    endtask

    // Per-instance monitor: reassemble the frame from SCLK rises and score it on done
    for (genvar g = 0; g < 2; g++) begin : g_mon
        logic [15:0] bits;
        logic [15:0] exp_w;
        int          nb, nl, blen, qsz;
        logic        psclk, pdone;

        always @(negedge clk_slow) begin
            if (!nReset) begin
                bits = '0; nb = 0; nl = 0; blen = 0; psclk = 1'b0; pdone = 1'b0;
            end else begin
                if (busy_v[g]) blen++;
                if (sclk_v[g] && !psclk) begin
                    bits = {bits[14:0], sdi_v[g]};
                    nb++;
                end
                if (!nlatch_v[g]) nl++;
                if (done_v[g]) begin
                    check("done_single_cycle", 32'(pdone), 32'd0);
                    qsz = (g == 0) ? q0.size() : q1.size();
                    check("done_expected", 32'(qsz > 0), 32'd1);
                    if (qsz > 0) begin
                        exp_w = (g == 0) ? q0.pop_front() : q1.pop_front();
                        check("frame_bits",     32'(bits),      32'(exp_w));
                        check("last_sent",      32'(last_v[g]), 32'(exp_w));
                        check("sclk_rises",     32'(nb),        32'd16);
                        check("nlatch_low_len", 32'(nl),        32'd2);
                        check("busy_to_done",   32'(blen),      32'd34);
                    end
                    bits = '0; nb = 0; nl = 0; blen = 0;
                end
                psclk = sclk_v[g];
                pdone = done_v[g];
            end
        end
    end

    initial begin
        #(100 * 60000);
        $display("FAIL watchdog: simulation exceeded time budget at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        nReset     = 1'b0;
        enable     = 1'b1;
        dac_strobe = 1'b0;
        dac_data   = '0;
        repeat (3) step();
        check_reset("reset");
        nReset = 1'b1;
        step();

        strobe(16'hA5C3, 4, 4);
        drain("a5c3");

        strobe(16'h8000, 4, 4);
        drain("h8000");
        strobe(16'h7FFF, 4, 4);
        drain("h7fff");
        check("ovr_none", 32'(ovr_v[0]), 32'd0);

        strobe(16'h1111, 4, 4);
        strobe(16'h2222, 4, 4);
        strobe(16'h3333, 4, 4);
        drain("overwrite");
        check("ovr_one",       32'(ovr_v[0]), 32'd1);
        check("ovr_one_model", 32'(ovr_v[1]), 32'(model_ovr));

        // Reset during bit 7 of a frame with a second word pending
        c0 = cyc;
        strobe(16'hC0DE, 4, 4);
        strobe(16'hBEEF, 4, 4);
        while (cyc < c0 + 18) step();
        nReset = 1'b0;
        model_reset();
        step();
        check_reset("midreset");
        nReset = 1'b1;
        repeat (60) step();
        strobe(16'h5A3C, 4, 4);
        drain("after_reset");

        enable = 1'b0;
        strobe(16'h1234, 4, 4);
        strobe(16'h4321, 4, 4);
        repeat (50) step();
        check("disabled_busy",  32'(busy_v[0]), 32'd0);
        check("disabled_ovr",   32'(ovr_v[0]),  32'(model_ovr));
        check("disabled_queue", 32'(q0.size()), 32'd0);
        enable = 1'b1;
        step();

        for (int i = 0; i < 24; i++) begin
            strobe(16'($urandom), $urandom_range(2, 5),
                   ($urandom_range(0, 1) == 1) ? $urandom_range(2, 10) : $urandom_range(30, 60));
        end
        drain("random");
        check("random_ovr0", 32'(ovr_v[0]), 32'(model_ovr));
        check("random_ovr1", 32'(ovr_v[1]), 32'(model_ovr));

        for (int i = 0; i < 300; i++) begin
            strobe(16'($urandom), 2, 2);
        end
        drain("saturate");
        check("ovr_saturated",       32'(ovr_v[0]), 32'd255);
        check("ovr_saturated_model", 32'(ovr_v[1]), 32'(model_ovr));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
